// File: rtl/pipe_stage_reg.sv
`timescale 1ns/1ps
// Valid/ready pipeline stage register with registered outputs and optional skid entry.
// Define PIPE_STAGE_SKID_EN to build the two-entry skid variant (in_ready from a flop).
module pipe_stage_reg #(
  parameter int DATA_W          = 68,
  parameter bit ZERO_ON_INVALID = 1'b1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [1:0]        occupancy
);

  logic              m_valid_q, m_valid_d;
  logic [DATA_W-1:0] m_data_q, m_data_d;
  logic [1:0]        occ_q, occ_d;
  logic              accept, drain;

`ifdef PIPE_STAGE_SKID_EN
  logic              s_valid_q, s_valid_d;
  logic [DATA_W-1:0] s_data_q, s_data_d;
  logic              in_ready_q, in_ready_d;

  assign in_ready = in_ready_q;
`else
  assign in_ready = ~m_valid_q | out_ready;
`endif

  assign accept    = in_valid & in_ready;
  assign drain     = m_valid_q & out_ready;
  assign out_valid = m_valid_q;
  assign out_data  = m_data_q;
  assign occupancy = occ_q;

  always_comb begin
    m_valid_d = m_valid_q;
    m_data_d  = m_data_q;
`ifdef PIPE_STAGE_SKID_EN
    s_valid_d = s_valid_q;
    s_data_d  = s_data_q;
`endif
    if (flush) begin
      m_valid_d = 1'b0;
`ifdef PIPE_STAGE_SKID_EN
      s_valid_d = 1'b0;
`endif
      if (ZERO_ON_INVALID) begin
        m_data_d = '0;
`ifdef PIPE_STAGE_SKID_EN
        s_data_d = '0;
`endif
      end
    end
`ifdef PIPE_STAGE_SKID_EN
    else if (!m_valid_q || drain) begin
      // A parked skid beat is older than anything offered now, so it goes first.
      if (s_valid_q) begin
        m_valid_d = 1'b1;
        m_data_d  = s_data_q;
        s_valid_d = 1'b0;
      end else if (accept) begin
        m_valid_d = 1'b1;
        m_data_d  = in_data;
      end else begin
        m_valid_d = 1'b0;
      end
    end else if (accept) begin
      s_valid_d = 1'b1;
      s_data_d  = in_data;
    end
`else
    else if (accept) begin
      m_valid_d = 1'b1;
      m_data_d  = in_data;
    end else if (drain) begin
      m_valid_d = 1'b0;
    end
`endif
  end

`ifdef PIPE_STAGE_SKID_EN
  assign in_ready_d = ~s_valid_d;
  assign occ_d      = {1'b0, m_valid_d} + {1'b0, s_valid_d};
`else
  assign occ_d      = {1'b0, m_valid_d};
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      m_valid_q  <= 1'b0;
      occ_q      <= 2'd0;
`ifdef PIPE_STAGE_SKID_EN
      s_valid_q  <= 1'b0;
      in_ready_q <= 1'b1;
`endif
    end else begin
      m_valid_q  <= m_valid_d;
      occ_q      <= occ_d;
`ifdef PIPE_STAGE_SKID_EN
      s_valid_q  <= s_valid_d;
      in_ready_q <= in_ready_d;
`endif
    end
  end

  // Payload flops only get a reset when the zeroing option asks for it.
  generate
    if (ZERO_ON_INVALID) begin : g_data_rst
      always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
          m_data_q <= '0;
`ifdef PIPE_STAGE_SKID_EN
          s_data_q <= '0;
`endif
        end else begin
          m_data_q <= m_data_d;
`ifdef PIPE_STAGE_SKID_EN
          s_data_q <= s_data_d;
`endif
        end
      end
    end else begin : g_data_norst
      always_ff @(posedge clk) begin
        m_data_q <= m_data_d;
`ifdef PIPE_STAGE_SKID_EN
        s_data_q <= s_data_d;
`endif
      end
    end
  endgenerate

endmodule

// File: tb/tb_pipe_stage_reg.sv
`timescale 1ns/1ps
// Scoreboard bench for pipe_stage_reg; honours PIPE_STAGE_SKID_EN the same way as the design.
module tb_pipe_stage_reg;
  localparam int W = 68;

  logic         clk = 1'b0;
  logic         rst;
  logic         flush;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] in_data;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] out_data;
  logic [1:0]   occupancy;

  int tests = 0;
  int fails = 0;

  logic [W-1:0] sb[$];

  logic         sInReady;
  logic         sOutValid;
  logic [W-1:0] sOutData;
  logic [1:0]   sOcc;

  pipe_stage_reg #(.DATA_W(W), .ZERO_ON_INVALID(1'b1)) dut (
    .clk       (clk),
    .rst       (rst),
    .flush     (flush),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .occupancy (occupancy)
  );

  always #5 clk = ~clk;

  // One clock of stimulus; outputs sampled mid-cycle and compared against the scoreboard.
  task automatic drive_cycle(input logic v, input logic [W-1:0] d, input logic rdy, input logic fl);
    logic expReady;
    logic accept;
    logic drain;
    @(negedge clk);
    in_valid  = v;
    in_data   = d;
    out_ready = rdy;
    flush     = fl;
    #1;
    sInReady  = in_ready;
    sOutValid = out_valid;
    sOutData  = out_data;
    sOcc      = occupancy;
`ifdef PIPE_STAGE_SKID_EN
    expReady = (sb.size() < 2);
`else
    expReady = (sb.size() == 0) || rdy;
`endif
    tests++;
    if (sOcc !== 2'(sb.size())) begin
      fails++;
      $display("[TB] FAIL occupancy: got %0d expected %0d", sOcc, sb.size());
    end
    tests++;
    if (sInReady !== expReady) begin
      fails++;
      $display("[TB] FAIL in_ready: got %b expected %b", sInReady, expReady);
    end
    tests++;
    if (sOutValid !== (sb.size() != 0)) begin
      fails++;
      $display("[TB] FAIL out_valid: got %b expected %b", sOutValid, sb.size() != 0);
    end
    if (sb.size() != 0) begin
      tests++;
      if (sOutData !== sb[0]) begin
        fails++;
        $display("[TB] FAIL out_data: got %h expected %h", sOutData, sb[0]);
      end
    end
    accept = v && expReady;
    drain  = (sb.size() != 0) && rdy;
    if (drain) void'(sb.pop_front());
    if (fl) sb.delete();
    else if (accept) sb.push_back(d);
    @(posedge clk);
  endtask

  task automatic test_reset();
    rst = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0; in_data = '0;
    #1 rst = 1'b0;
    #1;
    tests++;
    if (out_valid !== 1'b0 || occupancy !== 2'd0 || in_ready !== 1'b1 || out_data !== '0) begin
      fails++;
      $display("[TB] FAIL reset_state: got v=%b occ=%0d rdy=%b d=%h expected v=0 occ=0 rdy=1 d=0",
               out_valid, occupancy, in_ready, out_data);
    end
    repeat (2) @(negedge clk);
    rst = 1'b1;
    sb.delete();
  endtask

  task automatic test_stream();
    drive_cycle(1'b1, W'(1), 1'b1, 1'b0);
    for (int i = 2; i <= 16; i++) begin
      drive_cycle(1'b1, W'(i), 1'b1, 1'b0);
      tests++;
      if (sOutValid !== 1'b1 || sOutData !== W'(i - 1)) begin
        fails++;
        $display("[TB] FAIL stream_beat: got v=%b d=%h expected v=1 d=%h", sOutValid, sOutData, W'(i - 1));
      end
    end
    drive_cycle(1'b0, '0, 1'b1, 1'b0);
    drive_cycle(1'b0, '0, 1'b1, 1'b0);
  endtask

`ifdef PIPE_STAGE_SKID_EN
  task automatic test_stall();
    drive_cycle(1'b1, W'('hA), 1'b1, 1'b0);
    drive_cycle(1'b1, W'('hB), 1'b0, 1'b0);
    drive_cycle(1'b0, '0, 1'b0, 1'b0);
    tests++;
    if (sOcc !== 2'd2 || sInReady !== 1'b0 || sOutData !== W'('hA)) begin
      fails++;
      $display("[TB] FAIL stall_hold: got occ=%0d rdy=%b d=%h expected occ=2 rdy=0 d=a", sOcc, sInReady, sOutData);
    end
    drive_cycle(1'b0, '0, 1'b1, 1'b0);
    drive_cycle(1'b0, '0, 1'b1, 1'b0);
    tests++;
    if (sOutValid !== 1'b1 || sOutData !== W'('hB)) begin
      fails++;
      $display("[TB] FAIL stall_second: got v=%b d=%h expected v=1 d=b", sOutValid, sOutData);
    end
    drive_cycle(1'b0, '0, 1'b1, 1'b0);
  endtask
`else
  task automatic test_ready_follow();
    drive_cycle(1'b1, W'('h20), 1'b1, 1'b0);
    for (int i = 0; i < 8; i++) begin
      drive_cycle(1'b1, W'('h21 + i), (i % 2 == 1), 1'b0);
      tests++;
      if (sOutValid !== 1'b1 || sInReady !== (i % 2 == 1) || sOcc > 2'd1) begin
        fails++;
        $display("[TB] FAIL ready_follow: got v=%b rdy=%b occ=%0d expected v=1 rdy=%b occ<=1",
                 sOutValid, sInReady, sOcc, (i % 2 == 1));
      end
    end
    drive_cycle(1'b0, '0, 1'b1, 1'b0);
  endtask
`endif

  task automatic test_flush();
    drive_cycle(1'b1, W'(1), 1'b0, 1'b0);
`ifdef PIPE_STAGE_SKID_EN
    drive_cycle(1'b1, W'(2), 1'b0, 1'b0);
`endif
    drive_cycle(1'b1, W'('hC), 1'b0, 1'b1);
    drive_cycle(1'b0, '0, 1'b0, 1'b0);
    tests++;
    if (sOutValid !== 1'b0 || sOcc !== 2'd0 || sInReady !== 1'b1 || sOutData !== '0) begin
      fails++;
      $display("[TB] FAIL flush_full: got v=%b occ=%0d rdy=%b d=%h expected v=0 occ=0 rdy=1 d=0",
               sOutValid, sOcc, sInReady, sOutData);
    end
    drive_cycle(1'b1, W'('hC), 1'b1, 1'b1);
    drive_cycle(1'b0, '0, 1'b1, 1'b0);
    tests++;
    if (sOutValid !== 1'b0 || sOcc !== 2'd0) begin
      fails++;
      $display("[TB] FAIL flush_discard: got v=%b occ=%0d expected v=0 occ=0", sOutValid, sOcc);
    end
    drive_cycle(1'b1, W'(7), 1'b1, 1'b0);
    drive_cycle(1'b1, W'(8), 1'b1, 1'b1);
    drive_cycle(1'b0, '0, 1'b1, 1'b0);
    tests++;
    if (sOutValid !== 1'b0 || sOcc !== 2'd0 || sInReady !== 1'b1) begin
      fails++;
      $display("[TB] FAIL flush_drain: got v=%b occ=%0d rdy=%b expected v=0 occ=0 rdy=1", sOutValid, sOcc, sInReady);
    end
  endtask

  task automatic test_async_reset();
    drive_cycle(1'b1, W'(5), 1'b0, 1'b0);
    drive_cycle(1'b1, W'(6), 1'b0, 1'b0);
    @(negedge clk);
    in_valid = 1'b0; out_ready = 1'b0; flush = 1'b0;
    #2 rst = 1'b0;
    #1;
    tests++;
    if (out_valid !== 1'b0 || out_data !== '0 || occupancy !== 2'd0 || in_ready !== 1'b1) begin
      fails++;
      $display("[TB] FAIL async_reset: got v=%b d=%h occ=%0d rdy=%b expected v=0 d=0 occ=0 rdy=1",
               out_valid, out_data, occupancy, in_ready);
    end
    #1 rst = 1'b1;
    sb.delete();
    drive_cycle(1'b1, W'('h77), 1'b1, 1'b0);
    drive_cycle(1'b0, '0, 1'b1, 1'b0);
    tests++;
    if (sOutValid !== 1'b1 || sOutData !== W'('h77)) begin
      fails++;
      $display("[TB] FAIL post_reset_first: got v=%b d=%h expected v=1 d=77", sOutValid, sOutData);
    end
  endtask

  task automatic test_random();
    logic [95:0] r;
    for (int i = 0; i < 3000; i++) begin
      r = {$urandom, $urandom, $urandom};
      drive_cycle(1'($urandom_range(0, 1)), r[W-1:0], 1'($urandom_range(0, 3) != 0),
                  1'($urandom_range(0, 31) == 0));
    end
    repeat (4) drive_cycle(1'b0, '0, 1'b1, 1'b0);
  endtask

  initial begin
    test_reset();
    test_stream();
`ifdef PIPE_STAGE_SKID_EN
    test_stall();
`else
    test_ready_follow();
`endif
    test_flush();
    test_async_reset();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
